// File: rtl/if_id_pkg.sv
// Shared types and defaults for the IF/ID pipeline register with skid buffer.
package if_id_pkg;

   localparam int          ADDR_W_DEF    = 12;
   localparam int          INSTR_W_DEF   = 32;
   localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

   // Number of valid entries held: EMPTY=0, ONE=1 (main), FULL=2 (main+skid).
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_e;

endpackage

// File: rtl/if_id_pipe_skid_if.sv
// Handshake bundle between the IF stage, the IF/ID register and the ID stage.
// The slave modport is the pipeline register; the master modport is the
// IF/ID environment driving it.
interface if_id_pipe_skid_if
   import if_id_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int INSTR_W = INSTR_W_DEF
);
   logic               in_valid;
   logic               in_ready;
   logic [ADDR_W-1:0]  in_addr;
   logic [INSTR_W-1:0] in_instr;
   logic               flush;
   logic               out_valid;
   logic               out_ready;
   logic [ADDR_W-1:0]  out_addr;
   logic [INSTR_W-1:0] out_instr;
   logic [1:0]         occupancy;

   modport slave (
      input  in_valid, in_addr, in_instr, flush, out_ready,
      output in_ready, out_valid, out_addr, out_instr, occupancy
   );

   modport master (
      output in_valid, in_addr, in_instr, flush, out_ready,
      input  in_ready, out_valid, out_addr, out_instr, occupancy
   );
endinterface

// File: rtl/if_id_entry_reg.sv
// One addr+instr entry register with load enable and synchronous clear to
// addr 0 / NOP. Clear beats load so a flush always wins.
module if_id_entry_reg
   import if_id_pkg::*;
#(
   parameter int                 ADDR_W    = ADDR_W_DEF,
   parameter int                 INSTR_W   = INSTR_W_DEF,
   parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEF)
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               load_i,
   input  logic               clear_i,
   input  logic [ADDR_W-1:0]  addr_i,
   input  logic [INSTR_W-1:0] instr_i,
   output logic [ADDR_W-1:0]  addr_o,
   output logic [INSTR_W-1:0] instr_o
);
   logic [ADDR_W-1:0]  addr_q,  addr_d;
   logic [INSTR_W-1:0] instr_q, instr_d;

   // Next value: clear to NOP, else load, else hold.
   always_comb begin
      addr_d  = addr_q;
      instr_d = instr_q;
      if (clear_i) begin
         addr_d  = '0;
         instr_d = NOP_INSTR;
      end else if (load_i) begin
         addr_d  = addr_i;
         instr_d = instr_i;
      end
   end

   // Entry storage, reset to addr 0 / NOP.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         addr_q  <= '0;
         instr_q <= NOP_INSTR;
      end else begin
         addr_q  <= addr_d;
         instr_q <= instr_d;
      end
   end

   assign addr_o  = addr_q;
   assign instr_o = instr_q;
endmodule

// File: rtl/if_id_pipe_skid.sv
// IF/ID pipeline register with valid/ready handshake, 2-entry skid buffer and
// synchronous flush. in_ready is decoded from the state register only, so
// there is no combinational path from out_ready to in_ready.
// Optional build macro IF_ID_STALL_CNT_EN adds a saturating stall_cycles count.
module if_id_pipe_skid
   import if_id_pkg::*;
#(
   parameter int                 ADDR_W    = ADDR_W_DEF,
   parameter int                 INSTR_W   = INSTR_W_DEF,
   parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEF)
) (
   input  logic        clock,
   input  logic        reset_n,
`ifdef IF_ID_STALL_CNT_EN
   output logic [15:0] stall_cycles,
`endif
   if_id_pipe_skid_if.slave bus
);
   state_e state_q, state_d;

   logic accept, fire;
   logic main_load, skid_load;
   logic [ADDR_W-1:0]  main_addr_in;
   logic [INSTR_W-1:0] main_instr_in;
   logic [ADDR_W-1:0]  skid_addr, main_addr;
   logic [INSTR_W-1:0] skid_instr, main_instr;

   assign accept = bus.in_valid & bus.in_ready;
   assign fire   = bus.out_valid & bus.out_ready;

   // Next state and entry load strobes; flush overrides everything.
   always_comb begin
      state_d   = state_q;
      main_load = 1'b0;
      skid_load = 1'b0;
      if (!bus.flush) begin
         unique case (state_q)
            EMPTY: if (accept) begin
               main_load = 1'b1;
               state_d   = ONE;
            end
            ONE: begin
               if (accept && fire) begin
                  main_load = 1'b1;
               end else if (accept) begin
                  skid_load = 1'b1;
                  state_d   = FULL;
               end else if (fire) begin
                  state_d   = EMPTY;
               end
            end
            FULL: if (fire) begin
               main_load = 1'b1;
               state_d   = ONE;
            end
            default: state_d = EMPTY;
         endcase
      end else begin
         state_d = EMPTY;
      end
   end

   // Occupancy state register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state_q <= EMPTY;
      else          state_q <= state_d;
   end

   // Main refills from the older skid entry when draining FULL, else from IF.
   assign main_addr_in  = (state_q == FULL) ? skid_addr  : bus.in_addr;
   assign main_instr_in = (state_q == FULL) ? skid_instr : bus.in_instr;

   if_id_entry_reg #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .NOP_INSTR(NOP_INSTR)) u_main (
      .clock   (clock),
      .reset_n (reset_n),
      .load_i  (main_load),
      .clear_i (bus.flush),
      .addr_i  (main_addr_in),
      .instr_i (main_instr_in),
      .addr_o  (main_addr),
      .instr_o (main_instr)
   );

   if_id_entry_reg #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .NOP_INSTR(NOP_INSTR)) u_skid (
      .clock   (clock),
      .reset_n (reset_n),
      .load_i  (skid_load),
      .clear_i (bus.flush),
      .addr_i  (bus.in_addr),
      .instr_i (bus.in_instr),
      .addr_o  (skid_addr),
      .instr_o (skid_instr)
   );

   assign bus.in_ready  = (state_q != FULL);
   assign bus.out_valid = (state_q != EMPTY);
   assign bus.out_addr  = main_addr;
   assign bus.out_instr = main_instr;
   assign bus.occupancy = state_q;

`ifdef IF_ID_STALL_CNT_EN
   logic [15:0] stall_q, stall_d;

   // Saturating count of cycles where ID holds off a valid entry.
   always_comb begin
      stall_d = stall_q;
      if (bus.out_valid && !bus.out_ready && stall_q != 16'hFFFF)
         stall_d = stall_q + 16'd1;
   end

   // Stall counter register; only reset clears it, flush does not.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) stall_q <= '0;
      else          stall_q <= stall_d;
   end

   assign stall_cycles = stall_q;
`endif
endmodule

// File: tb/tb_if_id_pipe_skid.sv
// Directed-vector bench for if_id_pipe_skid. Inputs change 1ns after the
// rising edge; outputs are checked in the same window, away from the edge.
module tb_if_id_pipe_skid;
   import if_id_pkg::*;

   localparam int          AW  = 12;
   localparam int          IW  = 32;
   localparam logic [31:0] NOP = 32'h0000_0000;

   logic clock = 1'b0;
   logic reset_n;
   int   nvec = 0;
   int   nerr = 0;

   if_id_pipe_skid_if #(.ADDR_W(AW), .INSTR_W(IW)) bus ();

`ifdef IF_ID_STALL_CNT_EN
   logic [15:0] stall_cycles;
`endif

   if_id_pipe_skid #(.ADDR_W(AW), .INSTR_W(IW), .NOP_INSTR(NOP)) dut (
      .clock        (clock),
      .reset_n      (reset_n),
`ifdef IF_ID_STALL_CNT_EN
      .stall_cycles (stall_cycles),
`endif
      .bus          (bus)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic v, input logic [AW-1:0] a, input logic [IW-1:0] i,
                        input logic rdy, input logic fl);
      bus.in_valid  = v;
      bus.in_addr   = a;
      bus.in_instr  = i;
      bus.out_ready = rdy;
      bus.flush     = fl;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_ovalid"}, 32'(bus.out_valid), 32'd0);
      chk({tag, "_iready"}, 32'(bus.in_ready),  32'd1);
      chk({tag, "_occ"},    32'(bus.occupancy), 32'd0);
      chk({tag, "_addr"},   32'(bus.out_addr),  32'd0);
      chk({tag, "_instr"},  bus.out_instr,      NOP);
   endtask

   initial begin
      reset_n = 1'b0;
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      #3;
      chk_reset_state("rst0");
      @(negedge clock);
      reset_n = 1'b1;
      step();

      // Streaming at full rate.
      drive(1'b1, 12'h004, 32'h1111_0004, 1'b1, 1'b0);
      step();
      chk("st0_addr", 32'(bus.out_addr), 32'h004);
      chk("st0_occ",  32'(bus.occupancy), 32'd1);
      drive(1'b1, 12'h008, 32'h1111_0008, 1'b1, 1'b0);
      step();
      chk("st1_addr", 32'(bus.out_addr), 32'h008);
      chk("st1_occ",  32'(bus.occupancy), 32'd1);
      drive(1'b1, 12'h00C, 32'h1111_000C, 1'b1, 1'b0);
      step();
      chk("st2_addr",  32'(bus.out_addr), 32'h00C);
      chk("st2_instr", bus.out_instr, 32'h1111_000C);
      chk("st2_occ",   32'(bus.occupancy), 32'd1);
      drive(1'b0, 12'hFFF, 32'hDEAD_BEEF, 1'b1, 1'b0);
      step();
      chk("st3_ovalid", 32'(bus.out_valid), 32'd0);

      // Stall: both entries land, third offer is refused, main held.
      drive(1'b1, 12'h010, 32'h2222_0010, 1'b0, 1'b0);
      step();
      chk("sk0_occ",    32'(bus.occupancy), 32'd1);
      chk("sk0_iready", 32'(bus.in_ready), 32'd1);
      drive(1'b1, 12'h014, 32'h2222_0014, 1'b0, 1'b0);
      step();
      chk("sk1_occ",    32'(bus.occupancy), 32'd2);
      chk("sk1_iready", 32'(bus.in_ready), 32'd0);
      chk("sk1_addr",   32'(bus.out_addr), 32'h010);
      drive(1'b1, 12'h018, 32'h2222_0018, 1'b0, 1'b0);
      step();
      chk("sk2_addr",  32'(bus.out_addr), 32'h010);
      chk("sk2_instr", bus.out_instr, 32'h2222_0010);
      chk("sk2_occ",   32'(bus.occupancy), 32'd2);
      drive(1'b0, 12'h000, 32'h0, 1'b1, 1'b0);
      step();
      chk("sk3_addr",   32'(bus.out_addr), 32'h014);
      chk("sk3_instr",  bus.out_instr, 32'h2222_0014);
      chk("sk3_iready", 32'(bus.in_ready), 32'd1);
      chk("sk3_occ",    32'(bus.occupancy), 32'd1);
      step();
      chk("sk4_ovalid", 32'(bus.out_valid), 32'd0);

      // Flush while FULL drops the same-cycle input.
      drive(1'b1, 12'h040, 32'h3333_0040, 1'b0, 1'b0);
      step();
      drive(1'b1, 12'h044, 32'h3333_0044, 1'b0, 1'b0);
      step();
      chk("fl0_occ", 32'(bus.occupancy), 32'd2);
      drive(1'b1, 12'h020, 32'h3333_0020, 1'b0, 1'b1);
      step();
      chk_reset_state("fl1");
      drive(1'b0, 12'h000, 32'h0, 1'b1, 1'b0);
      step();
      chk("fl2_ovalid", 32'(bus.out_valid), 32'd0);
      chk("fl2_addr",   32'(bus.out_addr), 32'h000);

      // Drain ONE to EMPTY, then refill.
      drive(1'b1, 12'h030, 32'h4444_0030, 1'b0, 1'b0);
      step();
      chk("dr0_addr", 32'(bus.out_addr), 32'h030);
      drive(1'b0, 12'h000, 32'h0, 1'b1, 1'b0);
      step();
      chk("dr1_ovalid", 32'(bus.out_valid), 32'd0);
      chk("dr1_occ",    32'(bus.occupancy), 32'd0);
      drive(1'b1, 12'h034, 32'h4444_0034, 1'b1, 1'b0);
      step();
      chk("dr2_ovalid", 32'(bus.out_valid), 32'd1);
      chk("dr2_addr",   32'(bus.out_addr), 32'h034);
      chk("dr2_instr",  bus.out_instr, 32'h4444_0034);

      // Asynchronous reset with two entries held.
      drive(1'b1, 12'h050, 32'h5555_0050, 1'b0, 1'b0);
      step();
      drive(1'b1, 12'h054, 32'h5555_0054, 1'b0, 1'b0);
      step();
      chk("ar0_occ", 32'(bus.occupancy), 32'd2);
      drive(1'b0, 12'h000, 32'h0, 1'b0, 1'b0);
      #2;
      reset_n = 1'b0;
      #1;
      chk_reset_state("ar1");
      @(negedge clock);
      reset_n = 1'b1;
      step();

`ifdef IF_ID_STALL_CNT_EN
      chk("sc0_cnt", 32'(stall_cycles), 32'd0);
      drive(1'b1, 12'h060, 32'h6666_0060, 1'b0, 1'b0);
      step();
      drive(1'b0, 12'h000, 32'h0, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) step();
      chk("sc1_cnt", 32'(stall_cycles), 32'd5);
      force dut.stall_q = 16'hFFFD;
      #1;
      release dut.stall_q;
      step();
      chk("sc2_cnt", 32'(stall_cycles), 32'h0000_FFFE);
      step();
      chk("sc3_cnt", 32'(stall_cycles), 32'h0000_FFFF);
      step();
      chk("sc4_cnt", 32'(stall_cycles), 32'h0000_FFFF);
      drive(1'b0, 12'h000, 32'h0, 1'b0, 1'b1);
      step();
      chk("sc5_cnt", 32'(stall_cycles), 32'h0000_FFFF);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end
endmodule
